// File: rtl/seq_detect_scheduler_pkg.sv
// seq_detect_scheduler_pkg: shared state encodings and detector pattern
package seq_detect_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} ctl_t;
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} det_t;
  localparam logic [3:0] PATTERN = 4'b1010;
endpackage

// File: rtl/seq_detect_scheduler_if.sv
// seq_detect_scheduler_if: requester-side request/grant/result bundle
interface seq_detect_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*WORD_W-1:0] word;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [CNT_W-1:0]        match_cnt;
  modport master (output req, word, input gnt, done, match_cnt);
  modport slave (input req, word, output gnt, done, match_cnt);
endinterface

// File: rtl/seq_detect_scheduler_seq1010_serial_det.sv
// seq1010_serial_det: overlapping Mealy 1010 detector with synchronous clear
module seq1010_serial_det
  import seq_detect_scheduler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic hit
);
  det_t st, nxt;
  // hit only on the closing bit of the pattern while enabled
  assign hit = en && st == S3 && bit_in == PATTERN[0];
  // next-state table; a hit falls back to S2 so overlapping matches count
  always_comb begin
    nxt = S0;
    case (st)
      S0: nxt = bit_in ? S1 : S0;
      S1: nxt = bit_in ? S1 : S2;
      S2: nxt = bit_in ? S3 : S0;
      S3: nxt = bit_in ? S1 : S2;
      default: nxt = S0;
    endcase
  end
  // state register, cleared by reset or by the controller between words
  always_ff @(posedge clk) begin
    st <= (reset || clr) ? S0 : en ? nxt : st;
  end
endmodule

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: round-robin time-sharing of one serial 1010 detector
module seq_detect_scheduler
  import seq_detect_scheduler_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  seq_detect_scheduler_if.slave        bus,
  output logic                         busy,
  output logic                         ser_bit,
  output logic                         det_hit
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  ctl_t              state, nxt_state;
  logic [PW-1:0]     ptr, g, sel;
  logic              found, last, hit;
  logic [WORD_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  seq1010_serial_det u_det (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == IDLE),
    .en     (state == SHIFT),
    .bit_in (ser_bit),
    .hit    (hit)
  );
  assign found     = |bus.req;
  assign last      = bit_cnt == BW'(WORD_W - 1);
  assign ser_bit   = shift_reg[WORD_W-1];
  assign det_hit   = hit;
  assign busy      = state != IDLE;
  assign nxt_cnt   = cnt + CNT_W'(hit);
  assign bus.done  = state == REPORT ? bus.gnt : '0;
  // pick the first requester at or after the pointer, wrapping
  always_comb begin
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(ptr) + i) % N_REQ]) sel = PW'((int'(ptr) + i) % N_REQ);
    end
  end
  // controller next state
  always_comb begin
    nxt_state = IDLE;
    nxt_state = state == IDLE  ? (found ? SHIFT : IDLE) :
                state == SHIFT ? (last ? REPORT : SHIFT) : IDLE;
  end
  // controller state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : nxt_state;
  end
  // grant, serializer, match counting and pointer advance
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.gnt       <= '0;
      bus.match_cnt <= '0;
      ptr           <= '0;
      g             <= '0;
      shift_reg     <= '0;
      bit_cnt       <= '0;
      cnt           <= '0;
    end else if (state == IDLE && found) begin
      bus.gnt   <= N_REQ'(1) << sel;
      g         <= sel;
      shift_reg <= bus.word[int'(sel)*WORD_W +: WORD_W];
      bit_cnt   <= '0;
      cnt       <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= shift_reg << 1;
      bit_cnt   <= bit_cnt + 1'b1;
      cnt       <= nxt_cnt;
      if (last) bus.match_cnt <= nxt_cnt;
    end else if (state == REPORT) begin
      bus.gnt <= '0;
      ptr     <= g == PW'(N_REQ - 1) ? '0 : g + 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler: directed checks of arbitration, counting and reset abort
module tb_seq_detect_scheduler;
  logic clk = 0;
  logic reset = 1;
  logic busy, ser_bit, det_hit;
  int n_chk = 0;
  int n_pass = 0;
  seq_detect_scheduler_if #(.N_REQ(4), .WORD_W(8), .CNT_W(4)) bus ();
  seq_detect_scheduler #(.N_REQ(4), .WORD_W(8), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .busy    (busy),
    .ser_bit (ser_bit),
    .det_hit (det_hit)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic reset_dut();
    @(negedge clk);
    reset = 1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnt", bus.match_cnt, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 0;
  endtask
  task automatic wait_gnt(input logic [3:0] exp);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt != 0) break;
    end
    check("gnt", bus.gnt, exp);
  endtask
  task automatic wait_done(input logic [3:0] exp_gnt, input logic [3:0] exp_cnt);
    int t = 0;
    int bad = 0;
    while (t <= 20) begin
      @(posedge clk);
      #1;
      t++;
      if (bus.gnt != exp_gnt) bad++;
      if (bus.done != 0) break;
    end
    check("latency", t, 8);
    check("gnt_hold", bad, 0);
    check("done", bus.done, exp_gnt);
    check("match_cnt", bus.match_cnt, exp_cnt);
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 0);
    check("gnt_off", bus.gnt, 0);
    check("idle", busy, 0);
  endtask
  task automatic single(input logic [7:0] w, input logic [3:0] exp_cnt);
    @(negedge clk);
    bus.req = 4'b0001;
    bus.word = {24'h0, w};
    wait_gnt(4'b0001);
    wait_done(4'b0001, exp_cnt);
    bus.req = '0;
  endtask
  initial begin
    bus.req = '0;
    bus.word = '0;
    reset_dut();
    @(negedge clk);
    bus.req = 4'b0001;
    bus.word = {24'h0, 8'hAA};
    wait_gnt(4'b0001);
    check("busy", busy, 1);
    check("ser_bit0", ser_bit, 1);
    wait_done(4'b0001, 3);
    bus.req = '0;
    single(8'h5A, 1);
    single(8'hFF, 0);
    single(8'h00, 0);
    reset_dut();
    @(negedge clk);
    bus.word = {8'h0A, 8'hFF, 8'h5A, 8'hAA};
    bus.req = 4'b1111;
    wait_gnt(4'b0001); wait_done(4'b0001, 3);
    wait_gnt(4'b0010); wait_done(4'b0010, 1);
    wait_gnt(4'b0100); wait_done(4'b0100, 0);
    wait_gnt(4'b1000); wait_done(4'b1000, 1);
    wait_gnt(4'b0001); wait_done(4'b0001, 3);
    bus.req = 4'b0100;
    bus.word = {8'h0A, 8'hAA, 8'h00, 8'h5A};
    wait_gnt(4'b0100); wait_done(4'b0100, 3);
    bus.req = 4'b1001;
    wait_gnt(4'b1000); wait_done(4'b1000, 1);
    wait_gnt(4'b0001); wait_done(4'b0001, 1);
    bus.req = '0;
    @(negedge clk);
    bus.req = 4'b0001;
    bus.word = {24'h0, 8'hAA};
    wait_gnt(4'b0001);
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("det_hit_bit3", det_hit, 1);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    check("abort_gnt", bus.gnt, 0);
    check("abort_done", bus.done, 0);
    check("abort_cnt", bus.match_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_ser", ser_bit, 0);
    check("abort_hit", det_hit, 0);
    reset = 0;
    single(8'hAA, 3);
    @(negedge clk);
    bus.req = 4'b0001;
    bus.word = {24'h0, 8'hAA};
    wait_gnt(4'b0001);
    bus.req = '0;
    bus.word = {24'h0, 8'hFF};
    wait_done(4'b0001, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Time-shares one bit-serial "1010" pattern detector among N_REQ requesters.
- Each requester presents a WORD_W-bit word. The block arbitrates round-robin, latches the granted word and shifts it MSB-first through the detector.
- It counts detections and returns the count to the requester with a one-cycle done pulse.
- It sits between requester logic and the detector datapath and is the only block that drives the detector.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- WORD_W, 8, bits per word serialized per transaction (>=4).
- CNT_W, 4, match counter width; must hold WORD_W/2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset.
- req  input  N_REQ  per-requester request level.
- word  input  N_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W].
- gnt  output  N_REQ  one-hot grant, held for the whole transaction.
- done  output  N_REQ  one-cycle pulse to the granted requester when the result is valid.
- match_cnt  output  CNT_W  result of the last completed transaction, held until the next REPORT.
- busy  output  1  high in any state except IDLE.
- ser_bit  output  1  bit currently presented to the detector (debug).
- det_hit  output  1  combinational detector hit for the current bit (debug).

Behaviour:
- Reset: reset, synchronous, active-high.
  - All outputs go to 0; state IDLE; RR pointer 0; detector S0; shift register, bit counter and match counter 0.
  - Reset overrides everything, including mid-SHIFT. The aborted transaction produces no done pulse.
- Controller FSM (IDLE, SHIFT, REPORT):
  - IDLE: if req != 0 at edge k, grant the first asserted requester at or after the RR pointer, wrapping. At the same edge: gnt <= one-hot, shift_reg <= that word, bit_cnt <= 0, match counter <= 0, detector <= S0, next state SHIFT. If req == 0, stay in IDLE.
  - SHIFT: ser_bit = shift_reg[WORD_W-1] (combinational). Each edge: detector advances, shift_reg shifts left by 1, bit_cnt increments, match counter increments if det_hit. After the edge consuming bit WORD_W-1, the next state is REPORT.
  - REPORT: for one cycle, done[g] = 1 with match_cnt already updated (match_cnt <= final count at the SHIFT->REPORT edge). At exit: gnt <= 0, RR pointer <= (g+1) mod N_REQ, next state IDLE.
- Latency:
  - req sampled at edge k.
  - gnt high during cycles k+1 .. k+WORD_W+1.
  - SHIFT occupies WORD_W cycles; REPORT is cycle k+WORD_W+1.
  - Earliest next grant is at edge k+WORD_W+2.
- Handshake:
  - The requester holds req and word until its done pulse. The word is latched at grant, so later word changes are ignored.
  - Dropping req mid-transaction does not abort it.
  - req still high in the IDLE cycle after done is treated as a new request, subject to RR order.
- Detector (Mealy, overlapping, pattern 1010):
  - S0: 1->S1, 0->S0.
  - S1: 1->S1, 0->S2.
  - S2: 1->S3, 0->S0.
  - S3: 0->S2 with det_hit=1; 1->S1.
  - det_hit is valid only while in SHIFT; it is forced to 0 otherwise.
  - Detector state does not carry across transactions.
- Arithmetic: the match counter is unsigned and cannot overflow given the CNT_W constraint. No saturation logic.
- Simultaneous requests: exactly one grant. A non-requesting pointer position is skipped.

Decomposition:
- Shared header of localparams:
  - controller state encodings (IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2);
  - detector state encodings S0..S3;
  - PATTERN = 4'b1010.
- One sub-module, seq1010_serial_det:
  - ports clk, reset, clr, en, bit_in, hit;
  - clocked overlapping detector with a synchronous clear;
  - instantiated once, driven only by this controller.

Test Plan:
- Single requester 0, word=8'hAA -> gnt=4'b0001 for 9 cycles, done[0] pulse at cycle 9 after grant, match_cnt=3.
- word=8'h5A -> match_cnt=1 (checks S3 on 1 -> S1 and S1 on 1 -> S1). word=8'hFF -> 0. word=8'h00 -> 0.
- req=4'b1111 held continuously -> grants in order 0,1,2,3,0, each with its own correct count. No two gnt bits high simultaneously.
- After serving requester 2, req=4'b1001 -> requester 3 granted before requester 0.
- reset asserted at SHIFT bit 4 of word 8'hAA -> next cycle all outputs 0, no done. A subsequent req=4'b0001 is served with match_cnt=3 (no residue from the aborted word).
- req dropped and word changed one cycle after grant -> transaction completes on the latched word; done still pulses.
